// File: rtl/bram_march_bist.sv
// March BIST initiator for the single-port block RAM (optional BIST_ERR_COUNT_EN).
//
// Purpose : drives the RAM through a 4-element March test and reports the outcome.
//   The elements are w(P) ascending, r(P)/w(~P) ascending, r(~P)/w(P) descending,
//   and r(P) descending.
// Ports   : clk, rst_n (async, active-low), start    -> test control inputs
//           busy, done, pass                        -> test status
//           fail_addr, fail_expected, fail_actual   -> first-mismatch record
//           err_count                               -> mismatch count (0 unless
//                                                      BIST_ERR_COUNT_EN is defined)
//           write_enable, read_enable, address,
//           data_in, data_out                       -> RAM port, names match the RAM
// Macro   : BIST_ERR_COUNT_EN enables the saturating mismatch counter.
module bram_march_bist #(
    parameter int              RAM_WIDTH = 16,
    parameter int              RAM_DEPTH = 1024,
    parameter logic [RAM_WIDTH-1:0] PATTERN = 16'hA5A5,
    // A single-word RAM still needs one address bit.
    localparam int             AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [AW-1:0]        fail_addr,
    output logic [RAM_WIDTH-1:0] fail_expected,
    output logic [RAM_WIDTH-1:0] fail_actual,
    output logic [15:0]          err_count,
    output logic                 write_enable,
    output logic                 read_enable,
    output logic [AW-1:0]        address,
    output logic [RAM_WIDTH-1:0] data_in,
    input  logic [RAM_WIDTH-1:0] data_out
);

    typedef enum logic [2:0] {
        IDLE, M0, M1, M2, M3, CHECK, DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(RAM_DEPTH - 1);

    state_t               state;
    logic                 phase;      // 0 = read cycle, 1 = write cycle (M1/M2)
    logic                 found;
    logic [RAM_WIDTH-1:0] rd_exp;     // expected word for the read issued now
    logic                 chk_valid;  // data_out holds a read to check this cycle
    logic [RAM_WIDTH-1:0] chk_exp;
    logic [AW-1:0]        chk_addr;
    logic                 mismatch;

    assign mismatch = chk_valid && (data_out != chk_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            phase         <= 1'b0;
            found         <= 1'b0;
            rd_exp        <= '0;
            chk_valid     <= 1'b0;
            chk_exp       <= '0;
            chk_addr      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
            write_enable  <= 1'b0;
            read_enable   <= 1'b0;
            address       <= '0;
            data_in       <= '0;
        end else begin
            // Read data returns one cycle after the strobe; track it.
            chk_valid <= read_enable;
            chk_exp   <= rd_exp;
            chk_addr  <= address;

            if (mismatch && !found) begin
                found         <= 1'b1;
                fail_addr     <= chk_addr;
                fail_expected <= chk_exp;
                fail_actual   <= data_out;
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state         <= M0;
                        busy          <= 1'b1;
                        pass          <= 1'b0;
                        found         <= 1'b0;
                        fail_addr     <= '0;
                        fail_expected <= '0;
                        fail_actual   <= '0;
                        write_enable  <= 1'b1;
                        address       <= '0;
                        data_in       <= PATTERN;
                    end
                end
                M0: begin
                    if (address == LAST) begin
                        state        <= M1;
                        write_enable <= 1'b0;
                        read_enable  <= 1'b1;
                        address      <= '0;
                        rd_exp       <= PATTERN;
                        phase        <= 1'b0;
                    end else begin
                        address <= address + 1'b1;
                    end
                end
                M1: begin
                    if (!phase) begin
                        read_enable  <= 1'b0;
                        write_enable <= 1'b1;
                        data_in      <= ~PATTERN;
                        phase        <= 1'b1;
                    end else begin
                        write_enable <= 1'b0;
                        read_enable  <= 1'b1;
                        phase        <= 1'b0;
                        if (address == LAST) begin
                            state   <= M2;
                            address <= LAST;
                            rd_exp  <= ~PATTERN;
                        end else begin
                            address <= address + 1'b1;
                        end
                    end
                end
                M2: begin
                    if (!phase) begin
                        read_enable  <= 1'b0;
                        write_enable <= 1'b1;
                        data_in      <= PATTERN;
                        phase        <= 1'b1;
                    end else begin
                        write_enable <= 1'b0;
                        read_enable  <= 1'b1;
                        phase        <= 1'b0;
                        if (address == '0) begin
                            state   <= M3;
                            address <= LAST;
                            rd_exp  <= PATTERN;
                        end else begin
                            address <= address - 1'b1;
                        end
                    end
                end
                M3: begin
                    if (address == '0) begin
                        state       <= CHECK;
                        read_enable <= 1'b0;
                    end else begin
                        address <= address - 1'b1;
                    end
                end
                CHECK: begin
                    // The final M3 read is still being compared this cycle.
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= !(found || mismatch);
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BIST_ERR_COUNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (state == IDLE && start) begin
            err_q <= '0;
        end else if (mismatch && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_bram_march_bist.sv
// Self-checking bench for bram_march_bist: behavioural RAM with an injectable
// stuck-at bit, abstract March model, directed and randomized runs.
module tb_bram_march_bist;

    logic clk;
    logic rst_n;
    logic start;
    logic start1;

    logic        busy, done, pass;
    logic [3:0]  fail_addr;
    logic [15:0] fail_expected, fail_actual, err_count;
    logic        write_enable, read_enable;
    logic [3:0]  address;
    logic [15:0] data_in, data_out;

    logic        busy1, done1, pass1;
    logic [0:0]  fail_addr1;
    logic [15:0] fail_expected1, fail_actual1, err_count1;
    logic        we1, re1;
    logic [0:0]  address1;
    logic [15:0] din1, dout1;

    int checks;
    int failures;

    bit f_en;
    int f_addr;
    int f_bit;
    bit f_val;

    logic [15:0] mem16 [16];
    logic [15:0] mem1;

    bram_march_bist #(.RAM_WIDTH(16), .RAM_DEPTH(16), .PATTERN(16'hA5A5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_expected(fail_expected),
        .fail_actual(fail_actual), .err_count(err_count),
        .write_enable(write_enable), .read_enable(read_enable),
        .address(address), .data_in(data_in), .data_out(data_out)
    );

    bram_march_bist #(.RAM_WIDTH(16), .RAM_DEPTH(1), .PATTERN(16'hA5A5)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_addr(fail_addr1), .fail_expected(fail_expected1),
        .fail_actual(fail_actual1), .err_count(err_count1),
        .write_enable(we1), .read_enable(re1),
        .address(address1), .data_in(din1), .data_out(dout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAMs; the fault forces one read bit.
    always @(posedge clk) begin : ram16
        logic [15:0] v;
        v = mem16[address];
        if (f_en && int'(address) == f_addr) v[f_bit] = f_val;
        if (write_enable) mem16[address] <= data_in;
        if (read_enable) data_out <= v;
    end

    always @(posedge clk) begin
        if (we1) mem1 <= din1;
        if (re1) dout1 <= mem1;
    end

    always @(negedge clk) begin
        assert (!(write_enable && read_enable) && !(we1 && re1)) else begin
            failures++;
            $error("FAIL strobe_overlap observed=1 expected=0");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // March applied directly to an array of words.
    task automatic model(input bit fen, input int fa, input int fb,
                         input bit fv, output bit ep,
                         output logic [31:0] ea, output logic [31:0] ee,
                         output logic [31:0] eact, output logic [31:0] ecnt);
        logic [15:0] m [16];
        logic [15:0] p;
        logic [15:0] v;
        logic [15:0] rexp;
        logic [15:0] wv;
        int a;
        p = 16'hA5A5;
        ep = 1'b1;
        ea = 0;
        ee = 0;
        eact = 0;
        ecnt = 0;
        for (int e = 0; e < 4; e++) begin
            for (int i = 0; i < 16; i++) begin
                a = (e < 2) ? i : 15 - i;
                rexp = (e == 2) ? ~p : p;
                wv = (e == 1) ? ~p : p;
                if (e != 0) begin
                    v = m[a];
                    if (fen && a == fa) v[fb] = fv;
                    if (v != rexp) begin
                        if (ep) begin
                            ea = a;
                            ee = {16'h0, rexp};
                            eact = {16'h0, v};
                        end
                        ep = 1'b0;
                        ecnt++;
                    end
                end
                if (e != 3) m[a] = wv;
            end
        end
`ifndef BIST_ERR_COUNT_EN
        ecnt = 0;
`endif
    endtask

    // Pulse start, then follow the run cycle by cycle (cycle 1 = first after start).
    task automatic run16(input int repulse, output int done_cyc,
                         output bit busy_ok, output bit busy_at_done);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        done_cyc = -1;
        busy_ok = 1'b1;
        busy_at_done = 1'b1;
        while (n <= 300 && done_cyc < 0) begin
            if (done) begin
                done_cyc = n;
                busy_at_done = busy;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
            start = (n == repulse);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int repulse);
        int dc;
        bit bok, bad;
        bit ep;
        logic [31:0] ea, ee, eact, ecnt;
        model(f_en, f_addr, f_bit, f_val, ep, ea, ee, eact, ecnt);
        run16(repulse, dc, bok, bad);
        chk({tag, "_done_cycle"}, dc, 98);
        chk({tag, "_busy_run"}, {31'b0, bok}, 1);
        chk({tag, "_busy_at_done"}, {31'b0, bad}, 0);
        chk({tag, "_pass"}, {31'b0, pass}, {31'b0, ep});
        chk({tag, "_fail_addr"}, {28'b0, fail_addr}, ea);
        chk({tag, "_fail_expected"}, {16'b0, fail_expected}, ee);
        chk({tag, "_fail_actual"}, {16'b0, fail_actual}, eact);
        chk({tag, "_err_count"}, {16'b0, err_count}, ecnt);
    endtask

    initial begin
        int n;
        bit flag;
        int dc;
        checks = 0;
        failures = 0;
        start = 1'b0;
        start1 = 1'b0;
        f_en = 1'b0;
        f_addr = 0;
        f_bit = 0;
        f_val = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_pass", {31'b0, pass}, 0);
        chk("rst_strobes", {30'b0, write_enable, read_enable}, 0);
        chk("rst_address", {28'b0, address}, 0);
        chk("rst_data_in", {16'b0, data_in}, 0);
        chk("rst_fail", {fail_expected, fail_actual}, 0);
        chk("rst_fail_addr", {28'b0, fail_addr}, 0);
        chk("rst_err_count", {16'b0, err_count}, 0);
        chk("rst_d1_outputs", {29'b0, busy1, we1, re1}, 0);
        rst_n = 1'b1;

        check_run("clean", 0);

        f_en = 1'b1;
        f_addr = 5;
        f_bit = 0;
        f_val = 1'b0;
        check_run("fault5", 0);
        chk("fault5_const_addr", {28'b0, fail_addr}, 5);
        chk("fault5_const_exp", {16'b0, fail_expected}, 32'hA5A5);
        chk("fault5_const_act", {16'b0, fail_actual}, 32'hA5A4);
`ifdef BIST_ERR_COUNT_EN
        chk("fault5_const_cnt", {16'b0, err_count}, 2);
`else
        chk("fault5_const_cnt", {16'b0, err_count}, 0);
`endif

        f_en = 1'b0;
        check_run("after_fail", 0);

        check_run("repulse_m1", 20);

        // Abort with reset in the middle of M2.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 60; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", {30'b0, write_enable, read_enable}, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) flag = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) flag = 1'b1;
        end
        chk("abort_quiet", {31'b0, flag}, 0);
        check_run("post_abort", 0);

        for (int r = 0; r < 6; r++) begin
            f_en = $urandom_range(0, 3) != 0;
            f_addr = $urandom_range(0, 15);
            f_bit = $urandom_range(0, 15);
            f_val = $urandom_range(0, 1) == 1;
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) @(negedge clk);
            check_run($sformatf("rand%0d", r), 0);
        end
        f_en = 1'b0;

        // Single-word RAM.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        dc = -1;
        flag = 1'b0;
        while (n <= 50 && dc < 0) begin
            if (done1) dc = n;
            if (address1 != 1'b0) flag = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("d1_done_cycle", dc, 8);
        chk("d1_addr_zero", {31'b0, flag}, 0);
        chk("d1_pass", {31'b0, pass1}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
